// File: rtl/mem_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// mem_arbiter_pkg
// Shared definitions for the instruction/data memory arbiter:
//   - default address width and timeout length
//   - FSM state encoding (IDLE, BUSY, RESP)
//   - owner encoding used for the grant, the done pulse and the round-robin
//     last-served pointer
// No ports; imported by mem_arbiter and rr_arb2.
// -----------------------------------------------------------------------------
package mem_arbiter_pkg;

  localparam int AW_DEFAULT  = 10;
  localparam int TMO_DEFAULT = 15;

  // Width of the saturating BUSY-cycle counter
  localparam int CNT_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_t;

  typedef enum logic {
    OWN_I = 1'b0,
    OWN_D = 1'b1
  } owner_t;

endpackage

// File: rtl/mem_arbiter_rr_arb2.sv
// -----------------------------------------------------------------------------
// rr_arb2
// Two-way round-robin selector. Purely combinational: picks the single
// requester when only one is active, otherwise the one that was not served
// last.
// Ports:
//   i_req   [1:0]  request vector, bit 0 = instruction, bit 1 = data
//   i_last         owner that was served most recently
//   o_grant [1:0]  one-hot winner (same bit order as i_req), 0 when idle
// -----------------------------------------------------------------------------
module rr_arb2
  import mem_arbiter_pkg::*;
(
  input  logic   [1:0] i_req,
  input  owner_t       i_last,
  output logic   [1:0] o_grant
);

  // A tie goes to whichever side did not win the previous transaction,
  // so two permanently asserted requesters strictly alternate.
  always_comb begin
    o_grant = 2'b00;
    case (i_req)
      2'b01:   o_grant = 2'b01;
      2'b10:   o_grant = 2'b10;
      2'b11:   o_grant = (i_last == OWN_D) ? 2'b01 : 2'b10;
      default: o_grant = 2'b00;
    endcase
  end

endmodule

// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
// Shares one data memory between an instruction-cache refill port and a
// data-cache port. One transaction at a time: IDLE picks a winner, BUSY
// drives the memory strobe until mem_ready (or a timeout), RESP pulses the
// owner's done for one cycle. Every output is a register.
// Ports:
//   clk, RST                 clock (rising edge), synchronous active-high reset
//   i_req, i_addr            instruction refill request / word address
//   i_gnt, i_done, i_rdata   instruction grant, done pulse, captured line
//   d_req, d_we, d_addr,
//   d_wdata                  data request, 1 = word write / 0 = line read
//   d_gnt, d_done, d_rdata   data grant, done pulse, captured line
//   mem_rd_en, mem_wr_en     line read / word write strobes to memory
//   mem_addr, mem_wdata      latched address and write word
//   mem_ready, mem_rdata     memory completion and read line
//   err                      sticky timeout flag
// -----------------------------------------------------------------------------
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int AW  = AW_DEFAULT,
  parameter int TMO = TMO_DEFAULT
) (
  input  logic          clk,
  input  logic          RST,
  input  logic          i_req,
  input  logic [AW-1:0] i_addr,
  output logic          i_gnt,
  output logic          i_done,
  output logic [127:0]  i_rdata,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [31:0]   d_wdata,
  output logic          d_gnt,
  output logic          d_done,
  output logic [127:0]  d_rdata,
  output logic          mem_rd_en,
  output logic          mem_wr_en,
  output logic [AW-1:0] mem_addr,
  output logic [31:0]   mem_wdata,
  input  logic          mem_ready,
  input  logic [127:0]  mem_rdata,
  output logic          err
);

  state_t             r_state;
  owner_t             r_owner;
  owner_t             r_lastServed;
  logic               r_we;
  logic [CNT_W-1:0]   r_cnt;

  state_t             w_stateNext;
  owner_t             w_ownerNext;
  owner_t             w_lastNext;
  logic               w_weNext;
  logic [CNT_W-1:0]   w_cntNext;
  logic               w_errNext;
  logic               w_iGntNext;
  logic               w_dGntNext;
  logic               w_rdEnNext;
  logic               w_wrEnNext;
  logic [AW-1:0]      w_addrNext;
  logic [31:0]        w_wdataNext;
  logic               w_iDoneNext;
  logic               w_dDoneNext;
  logic [127:0]       w_iRdataNext;
  logic [127:0]       w_dRdataNext;
  logic [1:0]         w_win;
  logic               w_timeout;

  rr_arb2 u_rrArb (
    .i_req   ({d_req, i_req}),
    .i_last  (r_lastServed),
    .o_grant (w_win)
  );

  // Timeout fires on the BUSY edge where the counter already holds TMO.
  // The counter is zero-extended so a TMO above the counter range simply
  // never matches instead of being silently truncated.
  assign w_timeout = ({{(32 - CNT_W){1'b0}}, r_cnt} == TMO);

  // Next-state and next-output logic. Every register holds by default;
  // done pulses default low so they only last the one RESP cycle.
  // mem_ready takes priority over the timeout so a completion arriving on
  // the timeout edge is treated as a normal finish.
  always_comb begin
    w_stateNext  = r_state;
    w_ownerNext  = r_owner;
    w_lastNext   = r_lastServed;
    w_weNext     = r_we;
    w_cntNext    = r_cnt;
    w_errNext    = err;
    w_iGntNext   = i_gnt;
    w_dGntNext   = d_gnt;
    w_rdEnNext   = mem_rd_en;
    w_wrEnNext   = mem_wr_en;
    w_addrNext   = mem_addr;
    w_wdataNext  = mem_wdata;
    w_iDoneNext  = 1'b0;
    w_dDoneNext  = 1'b0;
    w_iRdataNext = i_rdata;
    w_dRdataNext = d_rdata;

    case (r_state)
      IDLE: begin
        if (w_win != 2'b00) begin
          w_stateNext = BUSY;
          w_cntNext   = '0;
          if (w_win[1]) begin
            w_ownerNext = OWN_D;
            w_addrNext  = d_addr;
            w_wdataNext = d_wdata;
            w_weNext    = d_we;
            w_dGntNext  = 1'b1;
            w_rdEnNext  = ~d_we;
            w_wrEnNext  = d_we;
          end else begin
            w_ownerNext = OWN_I;
            w_addrNext  = i_addr;
            w_weNext    = 1'b0;
            w_iGntNext  = 1'b1;
            w_rdEnNext  = 1'b1;
            w_wrEnNext  = 1'b0;
          end
        end
      end

      BUSY: begin
        if (mem_ready || w_timeout) begin
          w_stateNext = RESP;
          w_cntNext   = '0;
          w_lastNext  = r_owner;
          w_iGntNext  = 1'b0;
          w_dGntNext  = 1'b0;
          w_rdEnNext  = 1'b0;
          w_wrEnNext  = 1'b0;
          if (r_owner == OWN_D) begin
            w_dDoneNext = 1'b1;
          end else begin
            w_iDoneNext = 1'b1;
          end
          if (mem_ready) begin
            if (!r_we) begin
              if (r_owner == OWN_D) begin
                w_dRdataNext = mem_rdata;
              end else begin
                w_iRdataNext = mem_rdata;
              end
            end
          end else begin
            w_errNext = 1'b1;
          end
        end else if (r_cnt != '1) begin
          w_cntNext = r_cnt + {{(CNT_W - 1){1'b0}}, 1'b1};
        end
      end

      RESP: begin
        w_stateNext = IDLE;
      end

      default: begin
        w_stateNext = IDLE;
      end
    endcase
  end

  // State and output registers. Reset clears everything, including an
  // in-flight transaction, and points last-served at the data side so the
  // instruction side wins the first tie.
  always_ff @(posedge clk) begin
    if (RST) begin
      r_state      <= IDLE;
      r_owner      <= OWN_I;
      r_lastServed <= OWN_D;
      r_we         <= 1'b0;
      r_cnt        <= '0;
      err          <= 1'b0;
      i_gnt        <= 1'b0;
      d_gnt        <= 1'b0;
      mem_rd_en    <= 1'b0;
      mem_wr_en    <= 1'b0;
      mem_addr     <= '0;
      mem_wdata    <= '0;
      i_done       <= 1'b0;
      d_done       <= 1'b0;
      i_rdata      <= '0;
      d_rdata      <= '0;
    end else begin
      r_state      <= w_stateNext;
      r_owner      <= w_ownerNext;
      r_lastServed <= w_lastNext;
      r_we         <= w_weNext;
      r_cnt        <= w_cntNext;
      err          <= w_errNext;
      i_gnt        <= w_iGntNext;
      d_gnt        <= w_dGntNext;
      mem_rd_en    <= w_rdEnNext;
      mem_wr_en    <= w_wrEnNext;
      mem_addr     <= w_addrNext;
      mem_wdata    <= w_wdataNext;
      i_done       <= w_iDoneNext;
      d_done       <= w_dDoneNext;
      i_rdata      <= w_iRdataNext;
      d_rdata      <= w_dRdataNext;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_arbiter
// Self-checking bench for mem_arbiter: a table of directed transactions,
// hand-written reset and alternation sequences, then randomized traffic
// checked against a transaction-level model (who wins, what is captured,
// whether err is set).
// -----------------------------------------------------------------------------
module tb_mem_arbiter;

  localparam int AW  = 10;
  localparam int TMO = 15;

  logic          clk;
  logic          RST;
  logic          i_req;
  logic [AW-1:0] i_addr;
  logic          i_gnt;
  logic          i_done;
  logic [127:0]  i_rdata;
  logic          d_req;
  logic          d_we;
  logic [AW-1:0] d_addr;
  logic [31:0]   d_wdata;
  logic          d_gnt;
  logic          d_done;
  logic [127:0]  d_rdata;
  logic          mem_rd_en;
  logic          mem_wr_en;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata;
  logic          mem_ready;
  logic [127:0]  mem_rdata;
  logic          err;

  int checks   = 0;
  int failures = 0;

  // Transaction-level model state
  bit           mLast;
  bit           mErr;
  logic [127:0] mIRdata;
  logic [127:0] mDRdata;

  typedef struct {
    bit            reqI;
    bit            reqD;
    logic [AW-1:0] iAddr;
    logic [AW-1:0] dAddr;
    bit            dWe;
    logic [31:0]   dWdata;
    int            delay;
    logic [127:0]  rdata;
    bit            expWinD;
    bit            expErr;
  } vec_t;

  vec_t vecs [6];

  mem_arbiter #(.AW(AW), .TMO(TMO)) dut (
    .clk       (clk),
    .RST       (RST),
    .i_req     (i_req),
    .i_addr    (i_addr),
    .i_gnt     (i_gnt),
    .i_done    (i_done),
    .i_rdata   (i_rdata),
    .d_req     (d_req),
    .d_we      (d_we),
    .d_addr    (d_addr),
    .d_wdata   (d_wdata),
    .d_gnt     (d_gnt),
    .d_done    (d_done),
    .d_rdata   (d_rdata),
    .mem_rd_en (mem_rd_en),
    .mem_wr_en (mem_wr_en),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_ready (mem_ready),
    .mem_rdata (mem_rdata),
    .err       (err)
  );

  // 10 ns clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hard stop in case anything stalls
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // Advance one edge and settle just after it
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Control outputs packed as {i_gnt, d_gnt, mem_rd_en, mem_wr_en, i_done, d_done}
  function automatic logic [5:0] ctl();
    return {i_gnt, d_gnt, mem_rd_en, mem_wr_en, i_done, d_done};
  endfunction

  task automatic applyReset();
    i_req     = 1'b0;
    d_req     = 1'b0;
    d_we      = 1'b0;
    i_addr    = '0;
    d_addr    = '0;
    d_wdata   = '0;
    mem_ready = 1'b0;
    mem_rdata = '0;
    RST       = 1'b1;
    tick();
    tick();
    RST       = 1'b0;
    mLast     = 1'b1;
    mErr      = 1'b0;
    mIRdata   = '0;
    mDRdata   = '0;
    checkOutput("reset_ctl", {ctl(), err}, 7'b0);
    checkOutput("reset_addr", mem_addr, '0);
    checkOutput("reset_wdata", mem_wdata, '0);
    checkOutput("reset_i_rdata", i_rdata, '0);
    checkOutput("reset_d_rdata", d_rdata, '0);
  endtask

  // One full transaction. delay = edges after the strobe edge at which
  // mem_ready is sampled high; a negative delay means memory never answers.
  task automatic applyStimulus(input bit reqI, input bit reqD, input logic [AW-1:0] ia,
                               input logic [AW-1:0] da, input bit we, input logic [31:0] wd,
                               input int delay, input logic [127:0] rd, input bit expWinD,
                               input bit expErr, input bit dropReq);
    int          limit;
    logic [5:0]  expBusy;
    logic [AW-1:0] expAddr;
    bit          isWrite;
    isWrite  = expWinD && we;
    expBusy  = {!expWinD, expWinD, !isWrite, isWrite, 2'b00};
    expAddr  = expWinD ? da : ia;
    limit    = (delay < 0) ? TMO + 1 : delay;
    i_req    = reqI;
    d_req    = reqD;
    i_addr   = ia;
    d_addr   = da;
    d_we     = we;
    d_wdata  = wd;
    mem_ready = 1'b0;
    tick();
    checkOutput("grant_ctl", ctl(), expBusy);
    checkOutput("grant_addr", mem_addr, expAddr);
    if (isWrite) checkOutput("grant_wdata", mem_wdata, wd);
    // Requester inputs changing mid-transaction must not matter
    i_addr  = AW'($urandom);
    d_addr  = AW'($urandom);
    d_wdata = $urandom;
    d_we    = 1'($urandom);
    if (dropReq) begin
      if (expWinD) d_req = 1'b0;
      else i_req = 1'b0;
    end
    for (int k = 1; k <= limit; k++) begin
      if (k == delay) begin
        mem_ready = 1'b1;
        mem_rdata = rd;
      end else begin
        mem_rdata = {$urandom, $urandom, $urandom, $urandom};
      end
      tick();
      if (k < limit) checkOutput("busy_hold", {ctl(), mem_addr}, {expBusy, expAddr});
    end
    mem_ready = 1'b0;
    if (delay >= 0 && !isWrite) begin
      if (expWinD) mDRdata = rd;
      else mIRdata = rd;
    end
    checkOutput("done_ctl", ctl(), {4'b0000, !expWinD, expWinD});
    checkOutput("i_rdata", i_rdata, mIRdata);
    checkOutput("d_rdata", d_rdata, mDRdata);
    checkOutput("err", err, expErr);
    mLast = expWinD;
    if (expWinD) d_req = 1'b0;
    else i_req = 1'b0;
    tick();
    checkOutput("after_done", ctl(), 6'b0);
    checkOutput("err_hold", err, expErr);
  endtask

  initial begin
    int r;
    int dly;
    bit winD;
    bit we;
    RST = 1'b1;

    vecs[0] = '{1'b1, 1'b0, 10'h040, 10'h000, 1'b0, 32'h0, 2,
                128'h0123_4567_89AB_CDEF_0011_2233_4455_6677, 1'b0, 1'b0};
    vecs[1] = '{1'b0, 1'b1, 10'h000, 10'h3FF, 1'b1, 32'hDEADBEEF, 1,
                128'hFFFF_0000_FFFF_0000_FFFF_0000_FFFF_0000, 1'b1, 1'b0};
    vecs[2] = '{1'b1, 1'b1, 10'h0AA, 10'h155, 1'b0, 32'h0, 3,
                128'hA5A5_A5A5_5A5A_5A5A_1234_5678_9ABC_DEF0, 1'b0, 1'b0};
    vecs[3] = '{1'b1, 1'b1, 10'h0AA, 10'h155, 1'b0, 32'h0, TMO + 1,
                128'h1111_2222_3333_4444_5555_6666_7777_8888, 1'b1, 1'b0};
    vecs[4] = '{1'b1, 1'b0, 10'h005, 10'h000, 1'b0, 32'h0, -1,
                128'hBAD0_BAD0_BAD0_BAD0_BAD0_BAD0_BAD0_BAD0, 1'b0, 1'b1};
    vecs[5] = '{1'b0, 1'b1, 10'h000, 10'h200, 1'b0, 32'h0, 1,
                128'hCAFE_F00D_CAFE_F00D_CAFE_F00D_CAFE_F00D, 1'b1, 1'b1};

    applyReset();

    // mem_ready in IDLE with nobody requesting must be ignored
    mem_ready = 1'b1;
    mem_rdata = 128'hDEAD_DEAD_DEAD_DEAD_DEAD_DEAD_DEAD_DEAD;
    tick();
    tick();
    checkOutput("idle_ready_ctl", ctl(), 6'b0);
    checkOutput("idle_ready_rdata", {i_rdata, d_rdata} != '0, 1'b0);
    mem_ready = 1'b0;

    for (int i = 0; i < 6; i++) begin
      applyStimulus(vecs[i].reqI, vecs[i].reqD, vecs[i].iAddr, vecs[i].dAddr, vecs[i].dWe,
                    vecs[i].dWdata, vecs[i].delay, vecs[i].rdata, vecs[i].expWinD,
                    vecs[i].expErr, 1'b0);
    end

    // Both requesters held from reset: strict I, D, I, D alternation
    applyReset();
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1, 1'b1, AW'(16 + i), AW'(32 + i), 1'b0, 32'h0, 1 + i,
                    {4{32'(i + 1)}}, (i % 2) == 1, 1'b0, 1'b0);
    end

    // Reset in the middle of BUSY aborts silently
    i_req  = 1'b1;
    i_addr = 10'h077;
    tick();
    checkOutput("midrst_busy", ctl(), 6'b101000);
    tick();
    RST = 1'b1;
    tick();
    RST   = 1'b0;
    i_req = 1'b0;
    checkOutput("midrst_ctl", {ctl(), err}, 7'b0);
    checkOutput("midrst_addr", mem_addr, '0);
    checkOutput("midrst_rdata", {i_rdata, d_rdata} != '0, 1'b0);
    tick();
    checkOutput("midrst_nodone", ctl(), 6'b0);
    mLast   = 1'b1;
    mErr    = 1'b0;
    mIRdata = '0;
    mDRdata = '0;
    applyStimulus(1'b1, 1'b1, 10'h011, 10'h022, 1'b0, 32'h0, 2,
                  128'h7777_0000_7777_0000_7777_0000_7777_0000, 1'b0, 1'b0, 1'b0);

    // Randomized traffic against the transaction model
    for (int n = 0; n < 40; n++) begin
      r    = $urandom_range(1, 3);
      winD = (r == 3) ? !mLast : (r == 2);
      dly  = ($urandom_range(0, 7) == 0) ? -1 : $urandom_range(1, TMO + 1);
      if (dly < 0) mErr = 1'b1;
      we   = 1'($urandom);
      applyStimulus(r[0], r[1], AW'($urandom), AW'($urandom), we, $urandom, dly,
                    {$urandom, $urandom, $urandom, $urandom}, winD, mErr,
                    $urandom_range(0, 3) == 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
